// File: rtl/pong_pkg.sv
//==============================================================================
// pong_pkg: action encodings, ball state enum and score limits for the pong playfield.
// Rev 1.0
//==============================================================================
`default_nettype none

package pong_pkg;

   localparam logic [1:0] ACT_NONE  = 2'b00;
   localparam logic [1:0] ACT_RIGHT = 2'b01;
   localparam logic [1:0] ACT_LEFT  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      MISS = 2'd2
   } ball_st_t;

   localparam logic [3:0] MISS_MAX = 4'd15;

   // Horizontal direction implied by a spin code; codes other than left/right keep dflt.
   function automatic logic spin_dir(input logic [1:0] spin, input logic dflt);
      logic d;
      d = dflt;
      if (spin == ACT_RIGHT) d = 1'b1;
      else if (spin == ACT_LEFT) d = 1'b0;
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ball_axis.sv
//==============================================================================
// ball_axis: single-axis +/-1 stepper that reflects off 0 and max.
// Rev 1.0
//==============================================================================
`default_nettype none

module ball_axis #(
   parameter int W = 3
) (
   input  logic [W-1:0] pos,
   input  logic         dir,
   input  logic [W-1:0] max,
   output logic [W-1:0] npos,
   output logic         ndir
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_comb begin
      npos = pos;
      ndir = dir;
      if (!dir && pos == '0) begin
         ndir = 1'b1;
         npos = ONE;
      end else if (dir && pos == max) begin
         ndir = 1'b0;
         npos = max - ONE;
      end else if (dir) begin
         npos = pos + ONE;
      end else begin
         npos = pos - ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ball_state.sv
//==============================================================================
// ball_state: pong ball engine - diagonal motion, wall reflection, paddle bounce, miss count.
// Rev 1.0
//==============================================================================
`default_nettype none

module ball_state
   import pong_pkg::*;
#(
   parameter int BIT_WIDTH = 3,
   parameter int ROW_BITS  = 3,
   parameter int SIZE      = 2,
   parameter int START_X   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 serve,
   input  logic                 step,
   input  logic [BIT_WIDTH-1:0] paddle_left,
   input  logic [1:0]           action,
   output logic [BIT_WIDTH-1:0] ball_x,
   output logic [ROW_BITS-1:0]  ball_y,
   output logic                 dir_x,
   output logic                 dir_y,
   output logic                 hit,
   output logic                 miss,
   output logic [3:0]           misses,
   output logic                 busy
);

   localparam logic [BIT_WIDTH-1:0] X_MAX      = {BIT_WIDTH{1'b1}};
   localparam logic [BIT_WIDTH-1:0] X_START    = BIT_WIDTH'(START_X);
   localparam logic [ROW_BITS-1:0]  ROW_LAST   = {ROW_BITS{1'b1}};
   localparam logic [ROW_BITS-1:0]  ROW_APPR   = ROW_LAST - ROW_BITS'(1);
   localparam logic [ROW_BITS-1:0]  ROW_BOUNCE = ROW_LAST - ROW_BITS'(2);
   localparam logic [BIT_WIDTH:0]   PAD_SPAN   = (BIT_WIDTH+1)'(SIZE - 1);

   ball_st_t               state, state_n;
   logic [1:0]             spin, spin_n;
   logic [BIT_WIDTH-1:0]   x_n;
   logic [ROW_BITS-1:0]    y_n;
   logic                   dx_n, dy_n, hit_n, miss_n;
   logic [3:0]             misses_n;

   logic [BIT_WIDTH-1:0]   ax_pos;
   logic                   ax_dir;
   logic [ROW_BITS-1:0]    ay_pos;
   logic                   ay_dir;
   logic [BIT_WIDTH:0]     pad_lo, pad_hi, nx_ext;
   logic                   on_paddle;

   ball_axis #(.W(BIT_WIDTH)) u_axis_x (
      .pos  (ball_x),
      .dir  (dir_x),
      .max  (X_MAX),
      .npos (ax_pos),
      .ndir (ax_dir)
   );

   ball_axis #(.W(ROW_BITS)) u_axis_y (
      .pos  (ball_y),
      .dir  (dir_y),
      .max  (ROW_LAST),
      .npos (ay_pos),
      .ndir (ay_dir)
   );

   // Range compare one bit wider so paddle_left+SIZE-1 cannot wrap past the last column.
   assign pad_lo    = {1'b0, paddle_left};
   assign pad_hi    = pad_lo + PAD_SPAN;
   assign nx_ext    = {1'b0, ax_pos};
   assign on_paddle = (nx_ext >= pad_lo) && (nx_ext <= pad_hi);

   always_comb begin
      state_n  = state;
      spin_n   = spin;
      x_n      = ball_x;
      y_n      = ball_y;
      dx_n     = dir_x;
      dy_n     = dir_y;
      hit_n    = 1'b0;
      miss_n   = 1'b0;
      misses_n = misses;

      // A step in flight consumes the spin; a same-cycle action re-arms it.
      if (en && step && state == MOVE)
         spin_n = action;
      else if (action != ACT_NONE)
         spin_n = action;

      if (!en) begin
         state_n = IDLE;
         x_n     = X_START;
         y_n     = '0;
         dx_n    = 1'b1;
         dy_n    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (serve) begin
                  state_n = MOVE;
                  dy_n    = 1'b1;
                  dx_n    = spin_dir(spin, 1'b1);
               end
            end
            MOVE: begin
               if (step) begin
                  x_n  = ax_pos;
                  dx_n = ax_dir;
                  if (dir_y && ball_y == ROW_APPR) begin
                     if (on_paddle) begin
                        y_n   = ROW_BOUNCE;
                        dy_n  = 1'b0;
                        hit_n = 1'b1;
                        dx_n  = spin_dir(spin, ax_dir);
                     end else begin
                        y_n      = ROW_LAST;
                        miss_n   = 1'b1;
                        state_n  = MISS;
                        if (misses != MISS_MAX)
                           misses_n = misses + 4'd1;
                     end
                  end else begin
                     y_n  = ay_pos;
                     dy_n = ay_dir;
                  end
               end
            end
            MISS: begin
               if (step) begin
                  state_n = IDLE;
                  x_n     = X_START;
                  y_n     = '0;
                  dx_n    = 1'b1;
                  dy_n    = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               x_n     = X_START;
               y_n     = '0;
               dx_n    = 1'b1;
               dy_n    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         spin   <= ACT_NONE;
         ball_x <= X_START;
         ball_y <= '0;
         dir_x  <= 1'b1;
         dir_y  <= 1'b1;
         hit    <= 1'b0;
         miss   <= 1'b0;
         misses <= 4'd0;
      end else begin
         state  <= state_n;
         spin   <= spin_n;
         ball_x <= x_n;
         ball_y <= y_n;
         dir_x  <= dx_n;
         dir_y  <= dy_n;
         hit    <= hit_n;
         miss   <= miss_n;
         misses <= misses_n;
      end
   end

   assign busy = (state == MOVE) || (state == MISS);

endmodule

`default_nettype wire

// File: tb/tb_ball_state.sv
//==============================================================================
// tb_ball_state: directed scoreboard bench for the pong ball engine.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_ball_state;

   logic       clk = 1'b0;
   logic       rst, en, serve, step;
   logic [2:0] paddle_left;
   logic [1:0] action;
   logic [2:0] ball_x, ball_y;
   logic       dir_x, dir_y, hit, miss, busy;
   logic [3:0] misses;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string tag;
      int    x, y, dx, dy, hit, miss, ms, busy;
   } exp_t;

   exp_t sb[$];

   ball_state dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .serve       (serve),
      .step        (step),
      .paddle_left (paddle_left),
      .action      (action),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .dir_x       (dir_x),
      .dir_y       (dir_y),
      .hit         (hit),
      .miss        (miss),
      .misses      (misses),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input int x, input int y, input int dx, input int dy,
                       input int h, input int m, input int ms, input int b);
      exp_t e;
      e.tag = tag; e.x = x; e.y = y; e.dx = dx; e.dy = dy;
      e.hit = h; e.miss = m; e.ms = ms; e.busy = b;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, ".x"},      {5'b0, ball_x}, 8'(e.x));
         chk({e.tag, ".y"},      {5'b0, ball_y}, 8'(e.y));
         chk({e.tag, ".dir_x"},  {7'b0, dir_x},  8'(e.dx));
         chk({e.tag, ".dir_y"},  {7'b0, dir_y},  8'(e.dy));
         chk({e.tag, ".hit"},    {7'b0, hit},    8'(e.hit));
         chk({e.tag, ".miss"},   {7'b0, miss},   8'(e.miss));
         chk({e.tag, ".misses"}, {4'b0, misses}, 8'(e.ms));
         chk({e.tag, ".busy"},   {7'b0, busy},   8'(e.busy));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic idle_cycle(input string tag, input int x, input int y, input int dx, input int dy,
                             input int h, input int m, input int ms, input int b);
      push(tag, x, y, dx, dy, h, m, ms, b);
      tick();
   endtask

   task automatic do_step(input string tag, input int x, input int y, input int dx, input int dy,
                          input int h, input int m, input int ms, input int b);
      step = 1'b1;
      push(tag, x, y, dx, dy, h, m, ms, b);
      tick();
      step = 1'b0;
   endtask

   // Serve with a coincident step, which must not move the ball.
   task automatic serve_ball(input int ms);
      serve = 1'b1;
      step  = 1'b1;
      push("serve", 3, 0, 1, 1, 0, 0, ms, 1);
      tick();
      serve = 1'b0;
      step  = 1'b0;
   endtask

   task automatic first_six(input int ms);
      do_step("s1", 4, 1, 1, 1, 0, 0, ms, 1);
      do_step("s2", 5, 2, 1, 1, 0, 0, ms, 1);
      do_step("s3", 6, 3, 1, 1, 0, 0, ms, 1);
      do_step("s4", 7, 4, 1, 1, 0, 0, ms, 1);
      do_step("s5", 6, 5, 0, 1, 0, 0, ms, 1);
      do_step("s6", 5, 6, 0, 1, 0, 0, ms, 1);
   endtask

   initial begin
      int m;
      rst = 1'b1; en = 1'b1; serve = 1'b0; step = 1'b0;
      paddle_left = 3'd4; action = 2'b00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      push("reset", 3, 0, 1, 1, 0, 0, 0, 0);
      check_out();
      rst = 1'b0;
      do_step("idle_step", 3, 0, 1, 1, 0, 0, 0, 0);

      // Paddle bounce
      paddle_left = 3'd4;
      serve_ball(0);
      first_six(0);
      do_step("hit", 4, 5, 0, 0, 1, 0, 0, 1);
      idle_cycle("hit_drop", 4, 5, 0, 0, 0, 0, 0, 1);
      en = 1'b0;
      idle_cycle("park1", 3, 0, 1, 1, 0, 0, 0, 0);
      en = 1'b1;

      // Miss
      paddle_left = 3'd0;
      serve_ball(0);
      first_six(0);
      do_step("miss", 4, 7, 0, 1, 0, 1, 1, 1);
      idle_cycle("miss_hold", 4, 7, 0, 1, 0, 0, 1, 1);
      do_step("miss_exit", 3, 0, 1, 1, 0, 0, 1, 0);

      // Spin applied at the paddle
      paddle_left = 3'd4;
      serve_ball(1);
      first_six(1);
      action = 2'b01;
      idle_cycle("spin_latch", 5, 6, 0, 1, 0, 0, 1, 1);
      action = 2'b00;
      do_step("spin_hit", 4, 5, 1, 0, 1, 0, 1, 1);
      do_step("spin_next", 5, 4, 1, 0, 0, 0, 1, 1);
      en = 1'b0;
      idle_cycle("park2", 3, 0, 1, 1, 0, 0, 1, 0);
      en = 1'b1;

      // en dropped mid-flight, then serve while disabled
      serve_ball(1);
      do_step("e1", 4, 1, 1, 1, 0, 0, 1, 1);
      do_step("e2", 5, 2, 1, 1, 0, 0, 1, 1);
      do_step("e3", 6, 3, 1, 1, 0, 0, 1, 1);
      en = 1'b0;
      idle_cycle("en_drop", 3, 0, 1, 1, 0, 0, 1, 0);
      serve = 1'b1;
      idle_cycle("serve_no_en", 3, 0, 1, 1, 0, 0, 1, 0);
      serve = 1'b0;
      en = 1'b1;

      // Miss counter saturation
      paddle_left = 3'd0;
      m = 1;
      for (int i = 0; i < 16; i++) begin
         serve_ball(m);
         first_six(m);
         m = (m < 15) ? m + 1 : 15;
         do_step("sat_miss", 4, 7, 0, 1, 0, 1, m, 1);
         do_step("sat_exit", 3, 0, 1, 1, 0, 0, m, 0);
      end

      // Asynchronous reset mid-flight
      paddle_left = 3'd4;
      serve_ball(15);
      do_step("r1", 4, 1, 1, 1, 0, 0, 15, 1);
      do_step("r2", 5, 2, 1, 1, 0, 0, 15, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      push("rst_async", 3, 0, 1, 1, 0, 0, 0, 0);
      check_out();
      @(negedge clk);
      rst = 1'b0;
      idle_cycle("post_rst", 3, 0, 1, 1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
